// File: rtl/card_dealer_if.sv
// card_dealer_if: engine-side request/response bundle
// plus shoe status for the board-level deck button.
interface card_dealer_if;
  logic       shuffle;
  logic       req_p;
  logic       req_d;
  logic [3:0] cval_p;
  logic       ready_p;
  logic [3:0] cval_d;
  logic       ready_d;
  logic [5:0] cards_left;
  logic       empty;
  logic       busy;
  logic [1:0] debug_state;

  modport master (
    output shuffle, req_p, req_d,
    input  cval_p, ready_p, cval_d, ready_d,
    input  cards_left, empty, busy, debug_state
  );

  modport slave (
    input  shuffle, req_p, req_d,
    output cval_p, ready_p, cval_d, ready_d,
    output cards_left, empty, busy, debug_state
  );
endinterface

// File: rtl/card_dealer.sv
// card_dealer: shared 52-card shoe, round-robin between
// player and dealer engines, LFSR draw without replacement.
module card_dealer #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input logic     clk,
  input logic     rst,
  card_dealer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    PROBE = 2'b01,
    GRANT = 2'b10
  } state_t;

  state_t     state;
  state_t     state_d;
  logic [7:0] lfsr;
  logic [2:0] cnt [13];
  logic [3:0] idx;
  logic [5:0] left;
  logic       empty_q;
  logic       last;
  logic       win;
  logic       mask_p;
  logic       mask_d;
  logic [3:0] cval_p_q;
  logic [3:0] cval_d_q;
  logic       ready_p_q;
  logic       ready_d_q;

  logic       up;
  logic       ud;
  logic       pick;
  logic       hit;
  logic       take;
  logic       refill;
  logic       go_empty;
  logic       go_probe;
  logic [3:0] start;
  logic [3:0] idx_nx;
  logic [3:0] card;

  function automatic logic [3:0] rank_val(
    input logic [3:0] r
  );
    logic [3:0] v;
    unique case (1'b1)
      (r == 4'd0):  v = 4'd11;
      (r >= 4'd10): v = 4'd10;
      default:      v = r + 4'd1;
    endcase
    return v;
  endfunction

  // request masking, arbitration and probe helpers
  always_comb begin
    up     = bus.req_p & ~mask_p;
    ud     = bus.req_d & ~mask_d;
    pick   = (up & ud) ? ~last : ud;
    start  = (lfsr[3:0] >= 4'd13)
           ? lfsr[3:0] - 4'd13 : lfsr[3:0];
    idx_nx = (idx == 4'd12) ? 4'd0 : idx + 4'd1;
    hit    = (cnt[idx] != 3'd0);
    take   = (state == PROBE) & hit;
    card   = rank_val(idx);
  end

  // next-state and step decode
  always_comb begin
    state_d  = state;
    refill   = 1'b0;
    go_empty = 1'b0;
    go_probe = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.shuffle) begin
          refill = 1'b1;
        end else if (up | ud) begin
          if (empty_q) begin
            go_empty = 1'b1;
            state_d  = GRANT;
          end else begin
            go_probe = 1'b1;
            state_d  = PROBE;
          end
        end
      end
      PROBE: if (hit) state_d = GRANT;
      GRANT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // free-running LFSR, x^8+x^6+x^5+x^4+1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr <= SEED;
    end else begin
      lfsr <= {lfsr[6:0],
               lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  // shoe contents: refill or remove the probed card
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 13; i++) cnt[i] <= 3'd4;
      left    <= 6'd52;
      empty_q <= 1'b0;
    end else if (refill) begin
      for (int i = 0; i < 13; i++) cnt[i] <= 3'd4;
      left    <= 6'd52;
      empty_q <= 1'b0;
    end else if (take) begin
      cnt[idx] <= cnt[idx] - 3'd1;
      left     <= left - 6'd1;
      empty_q  <= (left == 6'd1);
    end
  end

  // arbiter history, winner latch, probe index, masks
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last   <= 1'b1;
      win    <= 1'b0;
      idx    <= 4'd0;
      mask_p <= 1'b0;
      mask_d <= 1'b0;
    end else begin
      mask_p <= ready_p_q;
      mask_d <= ready_d_q;
      if (go_empty | go_probe) begin
        win  <= pick;
        last <= pick;
      end
      if (go_probe) begin
        idx <= start;
      end else if ((state == PROBE) & ~hit) begin
        idx <= idx_nx;
      end
    end
  end

  // card values and one-cycle ready pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cval_p_q  <= 4'd0;
      cval_d_q  <= 4'd0;
      ready_p_q <= 1'b0;
      ready_d_q <= 1'b0;
    end else begin
      ready_p_q <= 1'b0;
      ready_d_q <= 1'b0;
      if (go_empty) begin
        if (pick) begin
          cval_d_q  <= 4'd0;
          ready_d_q <= 1'b1;
        end else begin
          cval_p_q  <= 4'd0;
          ready_p_q <= 1'b1;
        end
      end else if (take) begin
        if (win) begin
          cval_d_q  <= card;
          ready_d_q <= 1'b1;
        end else begin
          cval_p_q  <= card;
          ready_p_q <= 1'b1;
        end
      end
    end
  end

  assign bus.cval_p      = cval_p_q;
  assign bus.cval_d      = cval_d_q;
  assign bus.ready_p     = ready_p_q;
  assign bus.ready_d     = ready_d_q;
  assign bus.cards_left  = left;
  assign bus.empty       = empty_q;
  assign bus.busy        = (state != IDLE);
  assign bus.debug_state = state;

endmodule

// File: doc/card_dealer.md
# card_dealer

Shoe controller that serves the blackjack engines' card requests from a single shared 52-card shoe. Arbitrates round-robin between the player-side and dealer-side `blackjack` cores and draws pseudo-random cards without replacement, using an LFSR and per-rank counters. Each served card is returned on the requester's `cval`/`ready` pair. Sits between the engines and the board-level deck/shuffle button.

## Interface

- `SEED`, 8'hA5, LFSR reset value; must be nonzero.
- `clk`  in  1  system clock; all state updates on posedge.
- `rst`  in  1  asynchronous, active-low reset.
- `shuffle`  in  1  refill request; sampled only in IDLE.
- `req_p`  in  1  player-side card request; level, held until `ready_p`.
- `req_d`  in  1  dealer-side card request; level, held until `ready_d`.
- `cval_p`  out  4  card value for player, 2..11 (11 = ace), 0 = no card.
- `ready_p`  out  1  one-cycle pulse: `cval_p` valid.
- `cval_d`  out  4  card value for dealer, same encoding.
- `ready_d`  out  1  one-cycle pulse: `cval_d` valid.
- `cards_left`  out  6  cards remaining in shoe, 0..52.
- `empty`  out  1  high when `cards_left` == 0.
- `busy`  out  1  high in PROBE and GRANT.
- `debug_state`  out  2  FSM state: IDLE=00, PROBE=01, GRANT=10.

## Operation

- Shoe state is 13 rank counters, 3 bits each, with 4 cards per rank. Value map: rank 0 (ace) -> 11, ranks 1..9 -> 2..10, ranks 10..12 -> 10.
- LFSR: 8-bit Fibonacci, taps 8,6,5,4. It advances every cycle regardless of state. Start index = `lfsr[3:0]`, minus 13 if >= 13.
- Arbiter: round-robin with a `last` register; reset value = dealer, so the player wins the first tie. A lone requester is always granted. `last` updates on every grant.
- A served port's request is masked for the one cycle after its `ready` pulse, so a held `req` is not re-served.
- FSM:
  - IDLE: if `shuffle`, all counters = 4, `cards_left` = 52, stay in IDLE; `shuffle` takes priority over requests in the same cycle.
  - IDLE, else if any unmasked request and `empty`: grant the arbiter winner, drive its `cval` = 0, go to GRANT with no probe.
  - IDLE, else if any unmasked request: latch the winner, load the start index, go to PROBE.
  - PROBE, counter[idx] != 0: decrement it, decrement `cards_left`, register the mapped value into the winner's `cval`, go to GRANT.
  - PROBE, counter[idx] == 0: idx = (idx == 12) ? 0 : idx+1, stay in PROBE.
  - GRANT: winner's `ready` = 1 for exactly this cycle, then return to IDLE.
- `shuffle` outside IDLE is ignored; it is not queued.
- `cval_x` holds its value until the next grant to that port. The other port's `cval` is untouched.
- `empty` is registered and updates in the same cycle as `cards_left`.

## Timing

- Reset values: state IDLE, `lfsr` = SEED, `last` = dealer, counters = 4, `cards_left` = 52, `cval_p`/`cval_d` = 0, `ready_p`/`ready_d` = 0, `empty` = 0, `busy` = 0, masks clear.
- Latency: request sampled at edge N. Hit on first probe -> `ready` high in cycle N+2. Each probe miss adds one cycle. Worst case is 12 misses, giving `ready` at N+14.
- Empty shoe: `ready` high in cycle N+1 with `cval` = 0.
- Simultaneous requests: one grant per FSM pass. The loser keeps `req` high and is served on the next pass, 1 IDLE cycle after the winner's GRANT.
- Reset mid-operation, in any state: immediate return to reset values. Any pending grant is dropped and the requester must re-request.
- `cards_left` never wraps below 0, because the empty path bypasses PROBE.

## Test plan

- Reset hold, release with no requests -> `cards_left` = 52, `empty` = 0, `ready_*` = 0, `debug_state` = 00 for 20 cycles.
- 52 sequential `req_p` handshakes -> every `cval_p` is in 2..11; the sum of values = 380; count of 10s = 16, count of 11s = 4; `cards_left` reaches 0 and `empty` = 1.
- 53rd request after drain -> `ready_p` pulses one cycle after sampling with `cval_p` = 0; `cards_left` stays 0.
- `req_p` and `req_d` asserted in the same cycle after reset -> `ready_p` first, then `ready_d`. Each is a single-cycle pulse, each is served exactly once, and `cards_left` = 50.
- `shuffle` pulsed during PROBE -> ignored, `cards_left` decrements. `shuffle` in IDLE after 10 draws -> `cards_left` = 52, `empty` = 0.
- `rst` asserted while `debug_state` = 01 -> all outputs return to reset values asynchronously. After release, a new `req_d` is served normally.
